// File: rtl/scs8hd_setflag_sync.sv
// Synchronizer, glitch filter and rise-event handshake for the scs8hd_dfstp flag Q.
// Build option: define SCS8HD_SETFLAG_CNT_EN to include the saturating event counter and OVF.
module scs8hd_setflag_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CW          = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          Q_IN,
  input  logic          ACK,
  output logic          LEVEL,
  output logic          EVT,
  output logic          FLAG,
  output logic [CW-1:0] CNT,
  output logic          OVF
);

  // state | meaning
  // IDLE  | no request outstanding, waiting for a rise
  // PEND  | request raised (FLAG=1), waiting for ACK
  // HELD  | acknowledged while LEVEL still high, waiting for LEVEL to drop
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    HELD = 2'b10
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [3:0]             fcnt;
  logic [4:0]             fcnt_inc;
  logic                   flip;
  logic                   rise;

  assign s        = sync[SYNC_STAGES-1];
  assign fcnt_inc = {1'b0, fcnt} + 5'd1;
  assign flip     = (s != LEVEL) && (fcnt_inc == 5'(FILT_LEN));
  assign rise     = flip && s;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync  <= '0;
      fcnt  <= '0;
      LEVEL <= 1'b0;
      EVT   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], Q_IN};
      EVT  <= rise;
      if (s == LEVEL) begin
        fcnt <= '0;
      end else if (flip) begin
        LEVEL <= s;
        fcnt  <= '0;
      end else begin
        fcnt <= fcnt_inc[3:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A rise always lands in PEND, so a same-edge ACK can never drop an event.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: state_d = rise ? PEND : IDLE;
      PEND: begin
        if (rise)     state_d = PEND;
        else if (ACK) state_d = LEVEL ? HELD : IDLE;
        else          state_d = PEND;
      end
      HELD: begin
        if (rise)       state_d = PEND;
        else if (!LEVEL) state_d = IDLE;
        else            state_d = HELD;
      end
      default: state_d = IDLE;
    endcase
  end

  assign FLAG = (state_q == PEND);

`ifdef SCS8HD_SETFLAG_CNT_EN
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt;
  logic          ovf;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (rise) begin
      if (cnt == CNT_MAX) ovf <= 1'b1;
      else                cnt <= cnt + CW'(1);
    end
  end

  assign CNT = cnt;
  assign OVF = ovf;
`else
  assign CNT = '0;
  assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_scs8hd_setflag_sync.sv
// Scoreboard bench for scs8hd_setflag_sync: window-based reference model, per-cycle and per-event queues.
module tb_scs8hd_setflag_sync;

  localparam int SYNC = 2;
  localparam int FILT = 3;

  logic       CLK;
  logic       RESET;
  logic       Q_IN;
  logic       ACK;
  logic       level_d, evt_d, flag_d, ovf_d;
  logic [7:0] cnt_d;
  logic       level_s, evt_s, flag_s, ovf_s;
  logic [1:0] cnt_s;

  scs8hd_setflag_sync dut (
    .CLK(CLK), .RESET(RESET), .Q_IN(Q_IN), .ACK(ACK),
    .LEVEL(level_d), .EVT(evt_d), .FLAG(flag_d), .CNT(cnt_d), .OVF(ovf_d)
  );

  scs8hd_setflag_sync #(.CW(2)) dut_sat (
    .CLK(CLK), .RESET(RESET), .Q_IN(Q_IN), .ACK(ACK),
    .LEVEL(level_s), .EVT(evt_s), .FLAG(flag_s), .CNT(cnt_s), .OVF(ovf_s)
  );

  typedef struct packed {
    logic       level;
    logic       evt;
    logic       flag;
    logic [7:0] cnt8;
    logic       ovf8;
    logic [1:0] cnt2;
    logic       ovf2;
  } exp_t;

  typedef struct packed {
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic       ovf2;
  } ev_t;

  exp_t cyc_q[$];
  ev_t  ev_q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference model: LEVEL flips once S has disagreed with it on FILT consecutive
  // edges since the last flip/reset; S is Q_IN delayed SYNC edges, flushed by reset.
  bit smp[$];
  int t = 0;
  int last_change = -1;
  bit m_level = 0, m_flag = 0, m_evt = 0;
  int m_cnt8 = 0, m_cnt2 = 0;
  bit m_ovf8 = 0, m_ovf2 = 0;

  function automatic bit s_at(input int idx);
    if (idx < SYNC) return 1'b0;
    return smp[idx - SYNC];
  endfunction

  initial begin
    forever begin
      bit   flip, rise;
      exp_t e;
      ev_t  v;
      @(posedge CLK);
      smp.push_back(RESET ? 1'b0 : Q_IN);
      if (RESET) begin
        for (int k = 0; k < SYNC; k++) if (t - k >= 0) smp[t - k] = 1'b0;
        m_level = 0; m_flag = 0; m_evt = 0;
        m_cnt8 = 0; m_cnt2 = 0; m_ovf8 = 0; m_ovf2 = 0;
        last_change = t;
      end else begin
        flip = 1'b1;
        for (int k = 0; k < FILT; k++) begin
          if ((t - k) <= last_change || s_at(t - k) == m_level) flip = 1'b0;
        end
        rise = flip && !m_level;
        if (flip) begin
          m_level = !m_level;
          last_change = t;
        end
        m_evt = rise;
        if (rise)     m_flag = 1'b1;
        else if (ACK) m_flag = 1'b0;
        if (rise) begin
          if (m_cnt8 == 255) m_ovf8 = 1'b1; else m_cnt8++;
          if (m_cnt2 == 3)   m_ovf2 = 1'b1; else m_cnt2++;
        end
      end
      e.level = m_level;
      e.evt   = m_evt;
      e.flag  = m_flag;
`ifdef SCS8HD_SETFLAG_CNT_EN
      e.cnt8 = 8'(m_cnt8); e.ovf8 = m_ovf8;
      e.cnt2 = 2'(m_cnt2); e.ovf2 = m_ovf2;
`else
      e.cnt8 = '0; e.ovf8 = 1'b0;
      e.cnt2 = '0; e.ovf2 = 1'b0;
`endif
      cyc_q.push_back(e);
      if (m_evt) begin
        v.cnt8 = e.cnt8; v.cnt2 = e.cnt2; v.ovf2 = e.ovf2;
        ev_q.push_back(v);
      end
      t++;
    end
  end

  initial begin
    forever begin
      exp_t e;
      ev_t  v;
      @(negedge CLK);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("level",     16'(level_d), 16'(e.level));
        chk("evt",       16'(evt_d),   16'(e.evt));
        chk("flag",      16'(flag_d),  16'(e.flag));
        chk("cnt",       16'(cnt_d),   16'(e.cnt8));
        chk("ovf",       16'(ovf_d),   16'(e.ovf8));
        chk("sat_level", 16'(level_s), 16'(e.level));
        chk("sat_evt",   16'(evt_s),   16'(e.evt));
        chk("sat_flag",  16'(flag_s),  16'(e.flag));
        chk("sat_cnt",   16'(cnt_s),   16'(e.cnt2));
        chk("sat_ovf",   16'(ovf_s),   16'(e.ovf2));
      end
      if (evt_d === 1'b1) begin
        if (ev_q.size() == 0) begin
          chk("evt_unexpected", 16'(evt_d), 16'd0);
        end else begin
          v = ev_q.pop_front();
          chk("evt_cnt",     16'(cnt_d), 16'(v.cnt8));
          chk("evt_sat_cnt", 16'(cnt_s), 16'(v.cnt2));
          chk("evt_sat_ovf", 16'(ovf_s), 16'(v.ovf2));
        end
      end
    end
  end

  task automatic drive(input logic r, input logic q, input logic a, input int n);
    repeat (n) begin
      @(negedge CLK);
      RESET = r;
      Q_IN  = q;
      ACK   = a;
    end
  endtask

  initial begin
    RESET = 1'b1;
    Q_IN  = 1'b1;
    ACK   = 1'b0;
    // reset with Q_IN high, then release and detect it as a new event
    drive(1, 1, 0, 1);
    drive(0, 1, 0, 10);
    // level falls while PEND, FLAG holds until ACK
    drive(0, 0, 0, 8);
    drive(0, 0, 1, 1);
    drive(0, 0, 0, 4);
    // glitch rejection, then a 4-cycle pulse
    drive(0, 1, 0, 2);
    drive(0, 0, 0, 8);
    drive(0, 1, 0, 4);
    drive(0, 0, 0, 8);
    drive(0, 0, 1, 1);
    drive(0, 0, 0, 4);
    // handshake: ACK the cycle after FLAG rises, Q_IN still high
    drive(0, 1, 0, 5);
    drive(0, 1, 1, 1);
    drive(0, 1, 0, 3);
    drive(0, 0, 0, 8);
    drive(0, 1, 0, 8);
    // ACK lands on the same edge as a re-rise
    drive(0, 0, 0, 10);
    drive(0, 1, 0, 4);
    drive(0, 1, 1, 1);
    drive(0, 1, 0, 4);
    // saturation on the CW=2 instance
    drive(1, 0, 0, 2);
    repeat (5) begin
      drive(0, 1, 0, 6);
      drive(0, 0, 0, 8);
    end
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 4);
    // randomized segments
    for (int seg = 0; seg < 300; seg++) begin
      logic q;
      int   len;
      q   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 10));
      for (int c = 0; c < len; c++) begin
        drive(($urandom_range(0, 199) == 0), q, ($urandom_range(0, 3) == 0), 1);
      end
    end
    drive(0, 0, 0, 20);
    @(negedge CLK);
    @(negedge CLK);
    chk("evt_queue_empty", 16'(ev_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scs8hd_setflag_sync.md
# scs8hd_setflag_sync

Downstream consumer of the asynchronously-set flag flop (scs8hd_dfstp family). The block takes that flop's Q, which can assert at any time via SETB, and brings it into the CLK domain through a synchronizer and glitch filter. It then converts each filtered rising edge into a one-cycle event pulse, a sticky request flag with an acknowledge handshake, and a saturating event count. Everything is on one clock; no path through the block is asynchronous except the Q_IN input sampling.

## Interface
- SYNC_STAGES, 2, synchronizer depth; legal range 2..4.
- FILT_LEN, 3, consecutive agreeing samples required to change LEVEL; legal range 1..15.
- CW, 8, event counter width; legal range 2..16.

- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  reset; synchronous, active-high.
- Q_IN  input  1  Q of the upstream set flop; asynchronous to CLK.
- ACK  input  1  consumer acknowledge of FLAG; sampled on the CLK edge.
- LEVEL  output  1  synchronized, filtered level of Q_IN.
- EVT  output  1  one-cycle pulse on each filtered rising edge.
- FLAG  output  1  sticky request, held until acknowledged.
- CNT  output  CW  saturating count of rising edges.
- OVF  output  1  sticky saturation indicator.

## Operation
- **Reset:** while RESET=1 at a CLK edge, the block clears the following to 0: all sync stages, the filter count, LEVEL, EVT, FLAG, CNT and OVF. The FSM goes to IDLE. RESET takes priority over every other input. If Q_IN is still high when RESET drops, the block detects it as a new event after the full latency.
- **Synchronizer:** a chain of SYNC_STAGES flops samples Q_IN. Its last stage is S.
- **Filter:**
  - When S≠LEVEL, the filter count increments.
  - When S=LEVEL, the filter count clears to 0.
  - On the edge where the count would reach FILT_LEN, LEVEL takes the value of S and the count clears.
  - A pulse on S that lasts fewer than FILT_LEN cycles never changes LEVEL.
- **Rise:** a rise is the edge where LEVEL changes 0→1. On that edge:
  - EVT=1 for exactly one cycle.
  - CNT increments, holding at 2^CW−1. An increment attempted at saturation sets OVF, which stays set until RESET.
- **FSM states:**
  - IDLE (FLAG=0): on a rise, go to PEND.
  - PEND (FLAG=1):
    - ACK=1 with no rise on the same edge: go to HELD if LEVEL=1, otherwise go to IDLE.
    - A rise on the same edge as ACK: the rise wins. The FSM stays in PEND and the event is not lost.
    - LEVEL falling does not clear FLAG.
    - Further rises while in PEND still pulse EVT and count.
  - HELD (FLAG=0): go to IDLE when LEVEL=0. A LEVEL fall and a re-rise cannot land on the same edge.
- **ACK in other states:** ACK is ignored in IDLE and in HELD.
- **Encoding:** FSM state is binary-encoded (2 bits). The unused encoding returns to IDLE with FLAG=0.

## Timing
- All outputs are registered. No output has a combinational path from any input.
- **Rise latency:** Q_IN goes high before CLK edge 0 and stays high. LEVEL, EVT, FLAG and the new CNT all become visible after edge SYNC_STAGES+FILT_LEN−1. With defaults that is edge 4, i.e. the 5th sampling edge.
- **Fall latency:** the same latency applies to LEVEL falling.
- **ACK latency:** ACK sampled at edge n gives FLAG=0 after edge n. It is ignored if a rise occurs at edge n.
- **Minimum Q_IN high time for detection:** FILT_LEN CLK periods plus synchronizer uncertainty. Guaranteed at FILT_LEN+1 periods.

## Configuration
- **SCS8HD_SETFLAG_CNT_EN defined:** the CW-bit counter and the OVF logic are built as described above.
- **Not defined:** no counter flops are built. CNT is tied to 0 and OVF is tied to 0. LEVEL, EVT, FLAG and the FSM behave identically in both builds.

## Test plan
- **Reset:** RESET=1 for 2 edges with Q_IN=1 → all outputs 0. Release RESET, hold Q_IN=1 → LEVEL=EVT=FLAG=1 after the 5th edge (defaults), EVT low on the 6th, CNT=1.
- **Glitch rejection:** Q_IN high for 2 cycles, then low → LEVEL, EVT and FLAG stay 0 and CNT stays 0. Q_IN high for 4 cycles → exactly one EVT.
- **Handshake:**
  - ACK at the cycle after FLAG rises with Q_IN still 1 → FLAG=0, state HELD, no new EVT.
  - Q_IN then low, then high again → second EVT, FLAG=1, CNT=2.
- **Simultaneous ACK and rise:**
  - In PEND, drop Q_IN so LEVEL falls, then re-raise it so the rise lands on the same edge as ACK=1.
  - Required: FLAG stays 1, EVT=1, CNT increments.
- **Saturation:** CW=2 with 5 separated pulses → CNT reads 1, 2, 3, 3, 3; OVF goes to 1 on the 4th pulse and stays 1 until RESET.
- **Macro off:** rerun the handshake scenario → identical LEVEL, EVT and FLAG; CNT=0 and OVF=0 throughout.
